// File: rtl/mem_io_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_io_responder
// Purpose  : Byte-wide CPU memory/IO responder. It holds a 2**RAM_AW byte RAM
//            with one-cycle read latency and a memory-mapped IO window at
//            mem_a[17:16] == 2'b11. The IO window contains:
//              0x30000      read : pop the UART-in FIFO (0x00 when empty)
//                           write: push a nonzero byte to the UART-out FIFO
//              0x30004      write: raise program_done and queue 0x00
//              0x30004..7   read : little-endian bytes of the cycle counter
// Ports    : clk_in/rst_in (async active-low) / rdy_in (global stall)
//            mem_a, mem_dout, mem_wr -> mem_din        CPU bus
//            tx_valid, tx_data, tx_ready               UART-out stream
//            rx_valid, rx_data, rx_ready               UART-in stream
//            io_buffer_full, program_done              status
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_done
);

    localparam int                c_TX_PW    = $clog2(TX_DEPTH);
    localparam int                c_RX_PW    = $clog2(RX_DEPTH);
    localparam logic [c_TX_PW:0]  c_TX_FULL  = (c_TX_PW+1)'(TX_DEPTH);
    localparam logic [c_TX_PW:0]  c_TX_AFULL = (c_TX_PW+1)'(TX_DEPTH - 1);
    localparam logic [c_RX_PW:0]  c_RX_FULL  = (c_RX_PW+1)'(RX_DEPTH);

    // Storage (no reset: RAM contents survive reset, FIFO slots are
    // meaningless once the pointers are cleared)
    logic [7:0]         r_ram    [0:(1<<RAM_AW)-1];
    logic [7:0]         r_tx_mem [0:TX_DEPTH-1];
    logic [7:0]         r_rx_mem [0:RX_DEPTH-1];

    logic [c_TX_PW-1:0] r_tx_rd, r_tx_wr;
    logic [c_TX_PW:0]   r_tx_count;
    logic [c_RX_PW-1:0] r_rx_rd, r_rx_wr;
    logic [c_RX_PW:0]   r_rx_count;
    logic [31:0]        r_cycle;
    logic [7:0]         r_mem_din;
    logic               r_done;

    logic               w_active;
    logic               w_is_io;
    logic [15:0]        w_io_off;
    logic               w_off_data, w_off_ctrl, w_off_cnt;
    logic               w_wr_en, w_ram_we;
    logic               w_tx_req, w_tx_push, w_tx_pop;
    logic [7:0]         w_tx_byte;
    logic               w_rx_push, w_rx_pop;
    logic [7:0]         w_rd_data;
    logic               w_unused_addr;

    // Address bits above 17 are not decoded.
    assign w_unused_addr = ^mem_a[31:18];

    // rst_in is folded in so that no RAM/FIFO slot write lands on an edge
    // that coincides with an asserted reset.
    assign w_active   = rdy_in & rst_in;
    assign w_is_io    = (mem_a[17:16] == 2'b11);
    assign w_io_off   = mem_a[15:0];
    assign w_off_data = (w_io_off == 16'h0000);
    assign w_off_ctrl = (w_io_off == 16'h0004);
    assign w_off_cnt  = (w_io_off[15:2] == 14'h0001);

    // Writes of any kind are frozen once the program has signalled completion.
    assign w_wr_en    = w_active & mem_wr & ~r_done;
    assign w_ram_we   = w_wr_en & ~w_is_io;

    assign w_tx_req   = w_wr_en & w_is_io &
                        ((w_off_data & (mem_dout != 8'h00)) | w_off_ctrl);
    assign w_tx_byte  = w_off_ctrl ? 8'h00 : mem_dout;
    assign w_tx_pop   = w_active & tx_valid & tx_ready;
    // A full FIFO still accepts a push when a slot frees on the same edge.
    assign w_tx_push  = w_tx_req & ((r_tx_count != c_TX_FULL) | w_tx_pop);

    assign w_rx_push  = w_active & rx_valid & rx_ready;
    assign w_rx_pop   = w_active & ~mem_wr & w_is_io & w_off_data &
                        (r_rx_count != '0);

    assign tx_valid       = (r_tx_count != '0);
    assign tx_data        = r_tx_mem[r_tx_rd];
    assign io_buffer_full = (r_tx_count >= c_TX_AFULL);
    assign rx_ready       = (r_rx_count != c_RX_FULL);
    assign mem_din        = r_mem_din;
    assign program_done   = r_done;

    // Read-data selection. An empty RX FIFO reads as 0x00 even if a byte is
    // being pushed on this same edge; that byte stays queued.
    always_comb begin
        w_rd_data = 8'h00;
        if (!w_is_io) begin
            w_rd_data = r_ram[mem_a[RAM_AW-1:0]];
        end else if (w_off_data) begin
            w_rd_data = (r_rx_count != '0) ? r_rx_mem[r_rx_rd] : 8'h00;
        end else if (w_off_cnt) begin
            w_rd_data = r_cycle[{mem_a[1:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_ram_we) begin
            r_ram[mem_a[RAM_AW-1:0]] <= mem_dout;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= w_tx_byte;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mem_din  <= 8'h00;
            r_cycle    <= 32'h0;
            r_done     <= 1'b0;
            r_tx_rd    <= '0;
            r_tx_wr    <= '0;
            r_tx_count <= '0;
            r_rx_rd    <= '0;
            r_rx_wr    <= '0;
            r_rx_count <= '0;
        end else if (rdy_in) begin
            r_cycle <= r_cycle + 32'd1;
            if (!mem_wr) begin
                r_mem_din <= w_rd_data;
            end
            if (w_wr_en && w_is_io && w_off_ctrl) begin
                r_done <= 1'b1;
            end

            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rd <= r_tx_rd + 1'b1;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase

            if (w_rx_push) begin
                r_rx_wr <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + 1'b1;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_io_responder
// Purpose  : Directed self-checking bench for mem_io_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

    logic        clk_in   = 1'b0;
    logic        rst_in   = 1'b0;
    logic        rdy_in   = 1'b1;
    logic [31:0] mem_a    = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr   = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h0;
    logic        rx_ready;
    logic        program_done;

    int checks   = 0;
    int failures = 0;

    mem_io_responder #(
        .RAM_AW   (17),
        .TX_DEPTH (8),
        .RX_DEPTH (8)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .program_done   (program_done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive one bus access, let one rising edge
    // pass, return at the next falling edge.
    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] drain_exp [8];

        // RAM / decode vectors: {addr, wr, data, expected mem_din after edge}
        vecs[0]  = '{32'h0000_0123, 1'b1, 8'hA5, 8'h00};
        vecs[1]  = '{32'h0000_0123, 1'b0, 8'h00, 8'hA5};
        vecs[2]  = '{32'h0000_0124, 1'b1, 8'h3C, 8'hA5};
        vecs[3]  = '{32'h0001_FFFF, 1'b1, 8'h77, 8'hA5};
        vecs[4]  = '{32'h0000_0124, 1'b0, 8'h00, 8'h3C};
        vecs[5]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h77};
        vecs[6]  = '{32'h0003_0008, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{32'h0000_0123, 1'b1, 8'h5A, 8'h00};
        vecs[8]  = '{32'h0000_0123, 1'b0, 8'h00, 8'h5A};
        vecs[9]  = '{32'h0002_0123, 1'b1, 8'h99, 8'h5A};
        vecs[10] = '{32'hFFF0_0123, 1'b0, 8'h00, 8'h99};
        vecs[11] = '{32'h0003_0001, 1'b0, 8'h00, 8'h00};
        vecs[12] = '{32'h0003_000C, 1'b1, 8'h55, 8'h00};

        // ---- reset state ----
        @(posedge clk_in);
        @(negedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        check("rst_mem_din", {24'h0, mem_din}, 32'h00);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_io_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_done", {31'h0, program_done}, 32'h0);
        rst_in = 1'b1;

        // ---- RAM / decode table ----
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].a, vecs[i].wr, vecs[i].d);
            check($sformatf("vec%0d_mem_din", i), {24'h0, mem_din}, {24'h0, vecs[i].exp});
        end
        check("other_io_no_tx", {31'h0, tx_valid}, 32'h0);

        // ---- TX: 'H', 0x00 (ignored), 'i' ----
        cyc(32'h3_0000, 1'b1, 8'h48);
        cyc(32'h3_0000, 1'b1, 8'h00);
        cyc(32'h3_0000, 1'b1, 8'h69);
        check("hi_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("hi_tx_data_H", {24'h0, tx_data}, 32'h48);
        check("hi_io_full", {31'h0, io_buffer_full}, 32'h0);
        tx_ready = 1'b1;
        cyc(32'h0_0123, 1'b0, 8'h00);
        check("hi_tx_data_i", {24'h0, tx_data}, 32'h69);
        check("hi_tx_valid2", {31'h0, tx_valid}, 32'h1);
        cyc(32'h0_0123, 1'b0, 8'h00);
        check("hi_tx_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // ---- TX fill / almost-full / drop / push-while-popping ----
        for (int i = 1; i <= 6; i++) begin
            cyc(32'h3_0000, 1'b1, 8'(i));
        end
        check("fill6_io_full", {31'h0, io_buffer_full}, 32'h0);
        cyc(32'h3_0000, 1'b1, 8'h07);
        check("fill7_io_full", {31'h0, io_buffer_full}, 32'h1);
        cyc(32'h3_0000, 1'b1, 8'h08);
        check("fill8_io_full", {31'h0, io_buffer_full}, 32'h1);
        cyc(32'h3_0000, 1'b1, 8'h09);          // dropped: full, no pop
        check("full_head", {24'h0, tx_data}, 32'h01);
        tx_ready = 1'b1;
        cyc(32'h3_0000, 1'b1, 8'h0A);          // accepted: pop on same edge
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_valid", i), {31'h0, tx_valid}, 32'h1);
            check($sformatf("drain%0d_data", i), {24'h0, tx_data}, {24'h0, drain_exp[i]});
            cyc(32'h0_0123, 1'b0, 8'h00);
        end
        check("drain_empty", {31'h0, tx_valid}, 32'h0);
        check("drain_io_full", {31'h0, io_buffer_full}, 32'h0);
        tx_ready = 1'b0;

        // ---- RX: read while empty with a simultaneous push ----
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        cyc(32'h3_0000, 1'b0, 8'h00);
        check("rx_empty_read", {24'h0, mem_din}, 32'h00);
        rx_valid = 1'b0;
        cyc(32'h3_0000, 1'b0, 8'h00);
        check("rx_read_41", {24'h0, mem_din}, 32'h41);
        cyc(32'h3_0000, 1'b0, 8'h00);
        check("rx_read_empty2", {24'h0, mem_din}, 32'h00);

        // ---- RX fill to full, drop one, drain ----
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h50 + 8'(i);
            cyc(32'h0_0123, 1'b0, 8'h00);
        end
        check("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        rx_data = 8'hFF;
        cyc(32'h0_0123, 1'b0, 8'h00);
        rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(32'h3_0000, 1'b0, 8'h00);
            check($sformatf("rx_drain%0d", i), {24'h0, mem_din}, 32'h50 + i);
        end
        cyc(32'h3_0000, 1'b0, 8'h00);
        check("rx_drain_empty", {24'h0, mem_din}, 32'h00);
        check("rx_ready_again", {31'h0, rx_ready}, 32'h1);

        // ---- program_done, frozen writes, reset mid-operation ----
        cyc(32'h3_0004, 1'b1, 8'hFF);
        check("done_set", {31'h0, program_done}, 32'h1);
        check("done_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("done_tx_zero", {24'h0, tx_data}, 32'h00);
        cyc(32'h0_0123, 1'b1, 8'h11);
        cyc(32'h3_0000, 1'b1, 8'h5A);
        cyc(32'h0_0123, 1'b0, 8'h00);
        check("done_ram_kept", {24'h0, mem_din}, 32'h99);
        tx_ready = 1'b1;
        cyc(32'h0_0123, 1'b0, 8'h00);
        check("done_tx_one_entry", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        cyc(32'h0_0123, 1'b0, 8'h00);
        rx_valid = 1'b0;
        rst_in = 1'b0;
        #1;
        check("mid_rst_done", {31'h0, program_done}, 32'h0);
        check("mid_rst_mem_din", {24'h0, mem_din}, 32'h00);
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_io_full", {31'h0, io_buffer_full}, 32'h0);
        check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        cyc(32'h3_0000, 1'b0, 8'h00);
        check("rst_rx_discarded", {24'h0, mem_din}, 32'h00);

        // ---- cycle counter after 0x12345 active cycles, stall freeze ----
        rst_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        mem_a  = 32'h0_0123;
        mem_wr = 1'b0;
        repeat (32'h12345) @(posedge clk_in);
        @(negedge clk_in);
        cyc(32'h3_0004, 1'b0, 8'h00);
        check("cnt_b0", {24'h0, mem_din}, 32'h45);
        cyc(32'h3_0005, 1'b0, 8'h00);
        check("cnt_b1", {24'h0, mem_din}, 32'h23);
        cyc(32'h3_0006, 1'b0, 8'h00);
        check("cnt_b2", {24'h0, mem_din}, 32'h01);
        cyc(32'h3_0007, 1'b0, 8'h00);
        check("cnt_b3", {24'h0, mem_din}, 32'h00);
        cyc(32'h3_0004, 1'b0, 8'h00);
        check("cnt_b0_next", {24'h0, mem_din}, 32'h49);
        rdy_in   = 1'b0;
        mem_a    = 32'h0_0123;
        mem_wr   = 1'b1;
        mem_dout = 8'hEE;
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        check("stall_mem_din_held", {24'h0, mem_din}, 32'h49);
        rdy_in = 1'b1;
        cyc(32'h3_0004, 1'b0, 8'h00);
        check("stall_cnt_frozen", {24'h0, mem_din}, 32'h4A);
        cyc(32'h0_0123, 1'b0, 8'h00);
        check("stall_ram_kept", {24'h0, mem_din}, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
